// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit holding the HI/LO registers.
// The result is computed from the operand latches and committed on the final countdown edge.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  input  logic        start,
  input  logic        we,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          launch, done;
  logic [63:0]   prod_s, prod_u;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, div_q, div_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  // Signed division works on magnitudes so that 0x80000000 / -1 needs no special case.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_neg  = ~op_q[0] & a_q[31];
    b_neg  = ~op_q[0] & b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    div_q  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    div_r  = a_neg ? -r_mag : r_mag;
  end

  assign busy   = (cnt_q != '0);
  assign launch = start & ~busy & ~op[2];
  assign done   = (cnt_q == CW'(1));

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (launch) begin
      a_d   = A;
      b_d   = B;
      op_d  = op[1:0];
      cnt_d = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (done) begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = op_q[0] ? prod_u : prod_s;
        end else if (b_q != 32'd0) begin
          lo_d = div_q;
          hi_d = div_r;
        end
      end
    end else if (we) begin
      if (op == 3'd4) hi_d = A;
      if (op == 3'd5) lo_d = A;
    end
  end

  assign out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized and directed bench for md_unit against a longint reference model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  op = 3'd6;
  logic        start = 1'b0, we = 1'b0, hilo_sel = 1'b0;
  logic        busy;
  logic [31:0] out;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .we(we), .hilo_sel(hilo_sel), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic on the operands as launched.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin q = sa * sb; exp_hi = q[63:32]; exp_lo = q[31:0]; end
      3'd1: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      3'd3: if (b != 0) begin p = ua / ub; exp_lo = p[31:0]; p = ua % ub; exp_hi = p[31:0]; end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit restart, output int cycles);
    @(negedge clk);
    A = a; B = b; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      A = $urandom; B = $urandom;
      if (restart && cycles == 3) begin start = 1'b1; op = 3'd0; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    op = 3'd6;
    model(o, a, b);
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    A = a; op = o; we = 1'b1;
    @(negedge clk);
    we = 1'b0; op = 3'd6;
    model(o, a, 32'd0);
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    hilo_sel = 1'b0; #1 lo = out;
    hilo_sel = 1'b1; #1 hi = out;
    hilo_sel = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_hilo(hi, lo);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_mult;
    int c;
    logic [31:0] hi, lo;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, c);
    read_hilo(hi, lo);
    chk_cnt++; if (c != MC) $display("FAIL mult_busy got %0d want %0d", c, MC); else pass_cnt++;
    chk_cnt++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1)
      $display("FAIL mult_val got %h_%h want ffffffff_fffffff1", hi, lo); else pass_cnt++;
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, c);
    read_hilo(hi, lo);
    chk_cnt++; if (c != MC) $display("FAIL multu_busy got %0d want %0d", c, MC); else pass_cnt++;
    chk_cnt++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE)
      $display("FAIL multu_val got %h_%h want 00000001_fffffffe", hi, lo); else pass_cnt++;
  endtask

  task automatic test_div;
    int c;
    logic [31:0] hi, lo;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, c);
    read_hilo(hi, lo);
    chk_cnt++; if (c != DC) $display("FAIL div_busy got %0d want %0d", c, DC); else pass_cnt++;
    chk_cnt++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
      $display("FAIL div_val got %h_%h want ffffffff_fffffffd", hi, lo); else pass_cnt++;
    run_op(3'd3, 32'd7, 32'd2, 1'b0, c);
    read_hilo(hi, lo);
    chk_cnt++; if (hi !== 32'd1 || lo !== 32'd3)
      $display("FAIL divu_val got %h_%h want 00000001_00000003", hi, lo); else pass_cnt++;
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, c);
    read_hilo(hi, lo);
    chk_cnt++; if (hi !== 32'd0 || lo !== 32'h8000_0000)
      $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); else pass_cnt++;
  endtask

  task automatic test_divzero_restart;
    int c;
    logic [31:0] hi, lo;
    do_mt(3'd4, 32'h1234_5678);
    do_mt(3'd5, 32'd0);
    run_op(3'd3, 32'd9, 32'd0, 1'b1, c);
    read_hilo(hi, lo);
    chk_cnt++; if (c != DC) $display("FAIL divz_busy got %0d want %0d", c, DC); else pass_cnt++;
    chk_cnt++; if (hi !== 32'h1234_5678 || lo !== 32'd0)
      $display("FAIL divz_val got %h_%h want 12345678_00000000", hi, lo); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    logic [31:0] hi, lo;
    @(negedge clk);
    A = 32'd100; B = 32'd7; op = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL areset_busy got %b want 0", busy); else pass_cnt++;
    hilo_sel = 1'b0; #0.5;
    chk_cnt++; if (out !== 32'd0) $display("FAIL areset_lo got %h want 0", out); else pass_cnt++;
    hilo_sel = 1'b1; #0.5;
    chk_cnt++; if (out !== 32'd0) $display("FAIL areset_hi got %h want 0", out); else pass_cnt++;
    hilo_sel = 1'b0;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (15) @(negedge clk);
    read_hilo(hi, lo);
    chk_cnt++; if (busy !== 1'b0 || {hi, lo} !== 64'd0)
      $display("FAIL areset_stale got busy=%b %h_%h want 0", busy, hi, lo); else pass_cnt++;
  endtask

  task automatic test_mt_busy;
    int c;
    logic [31:0] hi, lo;
    @(negedge clk);
    A = 32'd6; B = 32'd7; op = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 32'hDEAD_BEEF; op = 3'd5; we = 1'b1;
    @(negedge clk);
    we = 1'b0; op = 3'd6;
    c = 1;
    while (busy && c < 200) begin c++; @(negedge clk); end
    model(3'd0, 32'd6, 32'd7);
    read_hilo(hi, lo);
    chk_cnt++; if (lo !== 32'd42 || hi !== 32'd0)
      $display("FAIL mt_busy got %h_%h want 00000000_0000002a", hi, lo); else pass_cnt++;
    A = 32'hCAFE_F00D; op = 3'd5; we = 1'b1;
    @(negedge clk);
    we = 1'b0; op = 3'd6;
    read_hilo(hi, lo);
    chk_cnt++; if (lo !== 32'hCAFE_F00D) $display("FAIL mt_after got %h want cafef00d", lo); else pass_cnt++;
    model(3'd5, 32'hCAFE_F00D, 32'd0);
  endtask

  task automatic test_random;
    int c, want;
    logic [2:0] o;
    logic [31:0] a, b, hi, lo;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      if (o >= 3'd4) begin
        do_mt(o, a);
      end else begin
        run_op(o, a, b, 1'b0, c);
        want = o[1] ? DC : MC;
        chk_cnt++; if (c != want) $display("FAIL rnd_busy[%0d] got %0d want %0d", i, c, want); else pass_cnt++;
      end
      read_hilo(hi, lo);
      chk_cnt++; if (hi !== exp_hi || lo !== exp_lo)
        $display("FAIL rnd_val[%0d] op=%0d a=%h b=%h got %h_%h want %h_%h", i, o, a, b, hi, lo, exp_hi, exp_lo);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_divzero_restart;
    test_async_reset;
    test_mt_busy;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the forwarded operands produced by the EX-stage 3-way forwarding muxes: rs-side mux feeds A, rt-side mux feeds B.
- Holds the architectural HI/LO registers and exposes busy to the hazard unit.
- Presents HI or LO on out for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy duration for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- start  input  1  one-cycle pulse launching op 0-3; qualified by the EX-stage valid.
- we  input  1  write strobe for op 4/5 (mthi/mtlo).
- hilo_sel  input  1  0 selects LO on out, 1 selects HI.
- busy  output  1  high while an operation is in flight.
- out  output  32  combinational: hilo_sel ? HI : LO.

Behaviour:
- Reset (async, any time): HI=0, LO=0, busy=0, counter=0, operand latches=0. An in-flight operation is discarded with no HI/LO update. out=0 immediately.
- Internal state: HI, LO, latched A/B, latched op, counter (width sufficient for max(MULT_CYCLES, DIV_CYCLES)).
- busy is registered and equals (counter != 0).
- Launch:
  - Occurs at the edge where start=1, busy=0 and op is in 0..3.
  - At that edge: latch A, B and op; load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - start with op 4..7 is ignored.
- Countdown:
  - Each edge with counter > 0 decrements it.
  - At the edge where counter goes 1->0, HI/LO are written from the latched operands.
  - busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles after the launch edge.
  - New HI/LO are visible on out in the first cycle busy=0.
- start while busy=1: ignored; operands are not re-latched and the counter is not reloaded. The hazard unit stalls D when (start || busy) and an md instruction is in D.
- mthi/mtlo: on we=1 with op=4 writes HI=A; with op=5 writes LO=A. Takes effect at that edge, no busy.
  - Ignored while busy=1 and at an edge where a launch occurs.
- Arithmetic, all on 32-bit latched operands:
  - MULT: signed 32x32 -> 64; {HI,LO} = product.
  - MULTU: unsigned 32x32 -> 64; {HI,LO} = product.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
- Divisor=0 (div or divu): full busy duration still runs; HI and LO are left unchanged at completion.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No trap.
- Operand changes on A/B after launch have no effect on the result.
- The result may be computed combinationally from the latches or iteratively. Only the completion-edge timing and the values are specified.

Test Plan:
- Reset, then mult A=0xFFFFFFFD (-3), B=5 with start pulse -> busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. out=0xFFFFFFF1 with hilo_sel=0.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE. Change A/B during busy -> result unchanged.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 -> LO=3, HI=1.
  - div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678, then divu A=9, B=0 -> busy 10 cycles, HI stays 0x12345678, LO stays 0.
  - Second start pulse during busy -> no restart; busy falls exactly 10 cycles after the first launch.
- Launch div, assert reset asynchronously mid-cycle at count 4 -> busy, HI, LO and out go to 0 without a clock edge. After release, no stale completion write occurs.
- mtlo with we=1 while busy -> LO unchanged. Same mtlo one cycle after busy falls -> LO=A.
